lock_cmd_parser: RTL and testbench
==================================

Name: lock_cmd_parser

Overview:
Consumes the byte stream produced by the UART receiver (data_rx qualified by rcv) and parses ASCII lock commands terminated by CR. It verifies a PIN against a stored code and drives the lock actuator through an unlock level. It returns a one-byte status through the UART transmitter's start/data_tx/ready handshake. It enforces a lockout after repeated wrong PINs.

Parameters:
PIN_LEN, 4, number of ASCII digits in a PIN (1..8).
DEFAULT_PIN, 32'h31323334, stored PIN as ASCII bytes ("1234"), first digit in the most significant used byte.
MAX_FAILS, 3, consecutive wrong PINs that trigger lockout (1..15).
UNLOCK_CYCLES, 12000000, clk cycles unlock stays high after a correct PIN.
LOCKOUT_CYCLES, 120000000, clk cycles lockout lasts.
TIMEOUT_CYCLES, 12000000, maximum idle gap between bytes inside a frame.

Ports:
clk  in  1  system clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
rcv  in  1  one-cycle strobe: data_rx holds a new byte
data_rx  in  8  received byte, valid when rcv=1
tx_ready  in  1  transmitter idle; tx_start is accepted only when high
tx_start  out  1  one-cycle request to send tx_data
tx_data  out  8  response byte, held stable from tx_start until tx_ready next returns high
unlock  out  1  actuator enable, level
lockout  out  1  lockout active, level
fail_cnt  out  4  consecutive wrong-PIN count

Behaviour:
- Reset (async, rstn=0) forces: tx_start=0, tx_data=0, unlock=0, lockout=0, fail_cnt=0, FSM=IDLE, all timers=0, digit buffer cleared.
- Frames:
  - "U" + PIN_LEN digits + CR (0x0D) = unlock request.
  - "L" + CR = lock.
- Parser FSM states: IDLE, DIGITS, EXPECT_CR, DISCARD, EVAL, SEND. Bytes are consumed only on cycles with rcv=1.
- IDLE:
  - 'U' (0x55) → DIGITS, digit index=0.
  - 'L' (0x4C) → EXPECT_CR with cmd=L.
  - CR or LF (0x0A) is ignored.
  - Any other byte → DISCARD.
- DIGITS:
  - Byte in '0'..'9' is shifted into the buffer and the index increments.
  - After the PIN_LEN-th digit → EXPECT_CR.
  - Non-digit → DISCARD. If that byte is CR, go straight to EVAL with a format error.
- EXPECT_CR: CR → EVAL; anything else → DISCARD.
- DISCARD: wait for CR, then EVAL with a format error. Format errors never change fail_cnt.
- EVAL (exactly 1 cycle) chooses the response:
  - Format error → 'E'.
  - cmd=L → unlock=0 immediately, response 'K'. This is accepted even during lockout.
  - cmd=U while lockout=1 → 'X'; no compare, fail_cnt unchanged.
  - cmd=U, PIN match → unlock=1, unlock timer loads UNLOCK_CYCLES (restarts if already unlocked), fail_cnt=0, response 'K'.
  - cmd=U, PIN mismatch → fail_cnt+1. If the new value equals MAX_FAILS: lockout=1, lockout timer loads LOCKOUT_CYCLES, response 'X'. Otherwise response 'E'.
- SEND: tx_data is set in EVAL. tx_start pulses for exactly one cycle on the first cycle in SEND with tx_ready=1, then FSM → IDLE. tx_start is never asserted while tx_ready=0.
- Bytes arriving (rcv=1) while in EVAL or SEND are dropped.
- Inter-byte timeout:
  - In DIGITS, EXPECT_CR or DISCARD, a counter resets on every rcv and increments otherwise.
  - Reaching TIMEOUT_CYCLES → IDLE silently: no response, no fail count, buffer cleared.
- Unlock timer: decrements while unlock=1. unlock drops on the cycle the count reaches 0. 'L' clears it at once.
- Lockout timer: decrements while lockout=1. On expiry, lockout=0 and fail_cnt=0 on the same edge.
- Simultaneous events:
  - Lockout expiry in the same cycle as EVAL of a U frame: EVAL sees the pre-expiry state (answers 'X').
  - Unlock expiry in the same cycle as a correct-PIN EVAL: the reload wins, so unlock stays 1.
- Reset mid-frame or mid-SEND: everything returns to reset values; a pending response is lost.

Test Plan:
Params for all scenarios: PIN_LEN=4, DEFAULT_PIN="1234", MAX_FAILS=3, UNLOCK_CYCLES=100, LOCKOUT_CYCLES=200, TIMEOUT_CYCLES=50, tx_ready tied 1 unless stated.
1. Send "U1234\r" → one tx_start with tx_data=0x4B ('K'). unlock=1 from the cycle after EVAL for 100 cycles, then 0. fail_cnt=0.
2. Send "U9999\r" three times → responses 'E','E','X' (0x45,0x45,0x58). fail_cnt 1,2,3; lockout=1. Then "U1234\r" → 'X', unlock stays 0. After 200 cycles lockout=0, fail_cnt=0; "U1234\r" → 'K'.
3. Send "U12A4\r", then "Q\r", then "U12345\r" → three 'E' responses. fail_cnt stays 0, unlock stays 0.
4. "U1234\r" then "L\r" at cycle 20 of the unlock window → unlock falls on the EVAL edge of L, response 'K'. Repeat "L\r" during lockout → 'K'.
5. Send "U12", wait 60 cycles, send "34\r" → no tx_start on the timeout. The stray "34\r" reaches DISCARD via '3' and gives one 'E'.
6. Hold tx_ready=0 during a "U1234\r" response → tx_start stays 0. Raise tx_ready → exactly one tx_start pulse, tx_data=0x4B. Assert rstn=0 mid-frame "U12" → all outputs return to reset values; a following "U1234\r" → 'K'.

Source files
------------

// File: rtl/lock_cmd_parser.sv
// ASCII lock command parser: "U<pin>\r" unlock and "L\r" lock frames from the UART
// receiver. Replies with a one-byte status and enforces a lockout after repeated bad PINs.
module lock_cmd_parser #(
  parameter int unsigned          PIN_LEN        = 4,
  parameter logic [8*PIN_LEN-1:0] DEFAULT_PIN    = 32'h31323334,
  parameter int unsigned          MAX_FAILS      = 3,
  parameter int unsigned          UNLOCK_CYCLES  = 12000000,
  parameter int unsigned          LOCKOUT_CYCLES = 120000000,
  parameter int unsigned          TIMEOUT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rcv,
  input  logic [7:0] data_rx,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       unlock,
  output logic       lockout,
  output logic [3:0] fail_cnt
);

  localparam int unsigned UW = $clog2(UNLOCK_CYCLES + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IW = $clog2(PIN_LEN + 1);

  localparam logic [7:0] CH_U  = 8'h55;
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_X = 8'h58;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGITS,
    S_EXPECT_CR,
    S_DISCARD,
    S_EVAL,
    S_SEND
  } state_t;

  state_t                 state;
  logic                   cmd_l;
  logic                   fmt_err;
  logic [8*PIN_LEN-1:0]   pin_buf;
  logic [IW-1:0]          idx;
  logic [TW-1:0]          idle_cnt;
  logic [UW-1:0]          unlock_tmr;
  logic [LW-1:0]          lock_tmr;

  logic       is_digit;
  logic       in_frame;
  logic       timed_out;
  logic [3:0] fail_next;

  assign is_digit  = data_rx inside {[8'h30:8'h39]};
  assign in_frame  = state inside {S_DIGITS, S_EXPECT_CR, S_DISCARD};
  assign timed_out = in_frame && !rcv && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign fail_next = fail_cnt + 4'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      cmd_l      <= 1'b0;
      fmt_err    <= 1'b0;
      pin_buf    <= '0;
      idx        <= '0;
      idle_cnt   <= '0;
      unlock_tmr <= '0;
      lock_tmr   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      unlock     <= 1'b0;
      lockout    <= 1'b0;
      fail_cnt   <= '0;
    end else begin
      tx_start <= 1'b0;

      // Timers run first so that EVAL assignments below override a same-cycle expiry.
      if (unlock) begin
        if (unlock_tmr == UW'(1)) unlock <= 1'b0;
        unlock_tmr <= unlock_tmr - 1'b1;
      end
      if (lockout) begin
        if (lock_tmr == LW'(1)) begin
          lockout  <= 1'b0;
          fail_cnt <= '0;
        end
        lock_tmr <= lock_tmr - 1'b1;
      end

      if (in_frame) idle_cnt <= rcv ? '0 : idle_cnt + 1'b1;

      if (timed_out) begin
        state    <= S_IDLE;
        pin_buf  <= '0;
        idx      <= '0;
        idle_cnt <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rcv) begin
              idle_cnt <= '0;
              fmt_err  <= 1'b0;
              cmd_l    <= 1'b0;
              idx      <= '0;
              if (data_rx == CH_U) begin
                state <= S_DIGITS;
              end else if (data_rx == CH_L) begin
                cmd_l <= 1'b1;
                state <= S_EXPECT_CR;
              end else if (data_rx != CH_CR && data_rx != CH_LF) begin
                state <= S_DISCARD;
              end
            end
          end
          S_DIGITS: begin
            if (rcv) begin
              if (is_digit) begin
                pin_buf <= (8*PIN_LEN)'({pin_buf, data_rx});
                idx     <= idx + 1'b1;
                if (idx == IW'(PIN_LEN - 1)) state <= S_EXPECT_CR;
              end else if (data_rx == CH_CR) begin
                fmt_err <= 1'b1;
                state   <= S_EVAL;
              end else begin
                state <= S_DISCARD;
              end
            end
          end
          S_EXPECT_CR: begin
            if (rcv) state <= (data_rx == CH_CR) ? S_EVAL : S_DISCARD;
          end
          S_DISCARD: begin
            if (rcv && data_rx == CH_CR) begin
              fmt_err <= 1'b1;
              state   <= S_EVAL;
            end
          end
          S_EVAL: begin
            state   <= S_SEND;
            pin_buf <= '0;
            idx     <= '0;
            if (fmt_err) begin
              tx_data <= RSP_E;
            end else if (cmd_l) begin
              unlock     <= 1'b0;
              unlock_tmr <= '0;
              tx_data    <= RSP_K;
            end else if (lockout) begin
              tx_data <= RSP_X;
            end else if (pin_buf == DEFAULT_PIN) begin
              unlock     <= 1'b1;
              unlock_tmr <= UW'(UNLOCK_CYCLES);
              fail_cnt   <= '0;
              tx_data    <= RSP_K;
            end else begin
              fail_cnt <= fail_next;
              if (fail_next == 4'(MAX_FAILS)) begin
                lockout  <= 1'b1;
                lock_tmr <= LW'(LOCKOUT_CYCLES);
                tx_data  <= RSP_X;
              end else begin
                tx_data <= RSP_E;
              end
            end
          end
          S_SEND: begin
            if (tx_ready) begin
              tx_start <= 1'b1;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_cmd_parser.sv
// Self-checking bench for lock_cmd_parser: directed and random frames against a
// timestamp-based reference model of the command rules.
module tb_lock_cmd_parser;

  localparam int PIN_LEN  = 4;
  localparam int MAX_FAIL = 3;
  localparam int UNLOCK_T = 100;
  localparam int LOCK_T   = 200;
  localparam int TO_T     = 50;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  localparam int K_NONE = 0;
  localparam int K_FMT  = 1;
  localparam int K_LOCK = 2;
  localparam int K_OK   = 3;
  localparam int K_BAD  = 4;

  typedef logic [7:0] bq_t[$];
  typedef int gq_t[$];

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       rcv = 1'b0;
  logic [7:0] data_rx = '0;
  logic       tx_ready = 1'b1;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       unlock;
  logic       lockout;
  logic [3:0] fail_cnt;

  lock_cmd_parser #(
    .PIN_LEN(PIN_LEN),
    .DEFAULT_PIN(32'h31323334),
    .MAX_FAILS(MAX_FAIL),
    .UNLOCK_CYCLES(UNLOCK_T),
    .LOCKOUT_CYCLES(LOCK_T),
    .TIMEOUT_CYCLES(TO_T)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .rcv(rcv),
    .data_rx(data_rx),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .unlock(unlock),
    .lockout(lockout),
    .fail_cnt(fail_cnt)
  );

  initial forever #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  bit     en = 1'b0;
  logic   ready_q = 1'b1;

  // Reference model: levels are expressed as "last cycle the level is high".
  longint     unl_until = -1;
  longint     lock_until = -1;
  bit         lk = 1'b0;
  int         fails = 0;
  bit         pend = 1'b0;
  longint     pend_edge = 0;
  int         pend_kind = K_NONE;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    unl_until  = -1;
    lock_until = -1;
    lk         = 1'b0;
    fails      = 0;
    pend       = 1'b0;
    exp_q.delete();
  endtask

  function automatic int predict(input bq_t b, input gq_t g);
    int    s = 0;
    bq_t   seg;
    string pin = "1234";
    bit    ok = 1'b1;
    if (b.size() == 0 || b[b.size()-1] != CR) return K_NONE;
    for (int i = 1; i < b.size(); i++) if (g[i] >= TO_T) s = i;
    for (int i = s; i < b.size(); i++) seg.push_back(b[i]);
    while (seg.size() > 0 && (seg[0] == CR || seg[0] == LF)) void'(seg.pop_front());
    if (seg.size() == 0) return K_NONE;
    if (seg.size() == 2 && seg[0] == 8'h4C) return K_LOCK;
    if (seg.size() == PIN_LEN + 2 && seg[0] == 8'h55) begin
      for (int i = 1; i <= PIN_LEN; i++) begin
        if (seg[i] < 8'h30 || seg[i] > 8'h39) return K_FMT;
        if (seg[i] != 8'(pin[i-1])) ok = 1'b0;
      end
      return ok ? K_OK : K_BAD;
    end
    return K_FMT;
  endfunction

  task automatic apply(input int kind, input longint e);
    bit locked = lk && (e - 1 <= lock_until);
    if (lk && e > lock_until) begin
      lk    = 1'b0;
      fails = 0;
    end
    case (kind)
      K_FMT:  exp_q.push_back(8'h45);
      K_LOCK: begin
        if (unl_until > e - 1) unl_until = e - 1;
        exp_q.push_back(8'h4B);
      end
      default: begin
        if (locked) begin
          exp_q.push_back(8'h58);
        end else if (kind == K_OK) begin
          unl_until = e + UNLOCK_T - 1;
          fails     = 0;
          exp_q.push_back(8'h4B);
        end else begin
          fails++;
          if (fails == MAX_FAIL) begin
            lk         = 1'b1;
            lock_until = e + LOCK_T - 1;
            exp_q.push_back(8'h58);
          end else begin
            exp_q.push_back(8'h45);
          end
        end
      end
    endcase
  endtask

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ready_q <= tx_ready;
  end

  always @(negedge clk) begin
    if (en) begin
      if (pend && cyc == pend_edge) begin
        apply(pend_kind, cyc);
        pend = 1'b0;
      end
      if (lk && cyc > lock_until) begin
        lk    = 1'b0;
        fails = 0;
      end
      check("unlock", 64'(unlock), 64'(cyc <= unl_until));
      check("lockout", 64'(lockout), 64'(lk && cyc <= lock_until));
      check("fail_cnt", 64'(fail_cnt), 64'(fails));
      if (tx_start === 1'b1) begin
        check("tx_start_ready", 64'(ready_q), 64'd1);
        if (exp_q.size() == 0) check("tx_extra", 64'(tx_start), 64'd0);
        else check("tx_data", 64'(tx_data), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    rstn = 1'b1;
  endtask

  function automatic bq_t q_of(input string s, input bit cr);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    if (cr) q.push_back(CR);
    return q;
  endfunction

  function automatic gq_t gaps(input int n, input int hi);
    gq_t g;
    for (int i = 0; i < n; i++) g.push_back(int'($urandom_range(hi, 0)));
    return g;
  endfunction

  // hold: 0 = tx_ready high, 1 = hold tx_ready low then release, 2 = hold then reset
  task automatic send(input bq_t b, input gq_t g, input int hold);
    int kind = predict(b, g);
    bit done = 1'b0;
    if (hold != 0) tx_ready = 1'b0;
    for (int i = 0; i < b.size(); i++) begin
      repeat (g[i]) tick();
      rcv     = 1'b1;
      data_rx = b[i];
      if (i == b.size() - 1 && kind != K_NONE) begin
        pend      = 1'b1;
        pend_edge = cyc + 2;
        pend_kind = kind;
      end
      tick();
      rcv = 1'b0;
    end
    if (b[b.size()-1] != CR) repeat (TO_T + 10) tick();
    if (hold != 0) begin
      repeat ($urandom_range(20, 3)) tick();
      check("held_resp", 64'(exp_q.size()), 64'(kind != K_NONE));
      if (hold == 2) begin
        do_reset();
        tx_ready = 1'b1;
        return;
      end
      tx_ready = 1'b1;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      if (!pend && exp_q.size() == 0) done = 1'b1;
      else tick();
    end
    check("resp_done", 64'(done), 64'd1);
  endtask

  task automatic run(input string s, input int hold = 0);
    bq_t b = q_of(s, 1'b1);
    send(b, gaps(b.size(), 2), hold);
  endtask

  initial begin
    bq_t b;
    gq_t g;
    #2;
    rstn = 1'b0;
    en   = 1'b1;
    do_reset();
    tick();

    run("U1234");
    repeat (110) tick();
    run("U9999"); run("U9999"); run("U9999");
    run("U1234");
    repeat (210) tick();
    run("U1234");
    run("U12A4"); run("Q"); run("U12345"); run("U"); run("L5");
    run("U1234");
    repeat (12) tick();
    run("L");
    run("U0000"); run("U0000"); run("U0000");
    run("L");
    repeat (210) tick();
    send(q_of("", 1'b1), '{0}, 0);
    send(q_of("U12", 1'b0), gaps(3, 2), 0);
    run("34");
    send(q_of("U1234", 1'b1), '{0, 1, 1, 49, 0, 0}, 0);
    send(q_of("U1234", 1'b1), '{0, 1, 1, 50, 0, 0}, 0);
    run("U1234", 1);
    run("U1234", 2);
    for (int i = 0; i < 3; i++) begin
      rcv = 1'b1;
      data_rx = (i == 0) ? 8'h55 : 8'(8'h30 + i);
      tick();
      rcv = 1'b0;
    end
    do_reset();
    run("U1234");

    for (int n = 0; n < 150; n++) begin
      int sel = int'($urandom_range(7, 0));
      b.delete();
      case (sel)
        0, 1: b = q_of("U1234", 1'b0);
        2, 3: begin
          b.push_back(8'h55);
          for (int i = 0; i < PIN_LEN; i++) b.push_back(8'(8'h30 + $urandom_range(9, 0)));
        end
        4: b = q_of("L", 1'b0);
        5: begin
          int len = int'($urandom_range(5, 1));
          for (int i = 0; i < len; i++) b.push_back(8'($urandom_range(8'h7E, 8'h20)));
        end
        default: begin
          int len = int'($urandom_range(6, 0));
          b.push_back(8'h55);
          for (int i = 0; i < len; i++) b.push_back(8'(8'h30 + $urandom_range(9, 0)));
        end
      endcase
      b.push_back(CR);
      g = gaps(b.size(), 3);
      if (sel == 6 && b.size() > 2) g[$urandom_range(b.size() - 1, 1)] = int'($urandom_range(60, 45));
      send(b, g, ($urandom_range(4, 0) == 0) ? 1 : 0);
      repeat (($urandom_range(9, 0) == 0) ? $urandom_range(250, 100) : $urandom_range(8, 0)) tick();
    end

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
